// File: rtl/ascon_pkg.sv
// Shared constants and controller state encoding for the ASCON-128 slice.
// Latency: n/a (declarations only).
// Backpressure: n/a. Controller feature macro: ASCON_CTRL_ABORT_EN.
package ascon_pkg;

  // Rounds of the initialization / finalization permutation p^a.
  localparam int C_ROUNDS_A = 12;

  // ASCON-128 initialization vector; the host places it in front of K and N.
  localparam logic [63:0] C_IV_128 = 64'h80400C0600000000;

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_INIT    = 3'd1,
    CS_AD_WAIT = 3'd2,
    CS_AD_RUN  = 3'd3,
    CS_PT_WAIT = 3'd4,
    CS_PT_RUN  = 3'd5,
    CS_FINAL   = 3'd6,
    CS_DONE    = 3'd7
  } t_ctrl_state;

endpackage

// File: rtl/ascon_round_counter.sv
// Round index counter shared by INIT, data-block runs and FINAL.
// Latency: load/increment visible the cycle after the request.
// Backpressure: none; holds its value when neither load nor inc is set.
module ascon_round_counter
  import ascon_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_inc,
  output logic [3:0] o_rnd,
  output logic       o_last
);

  // Every phase ends on the last p^a round index, so a single terminal count suffices.
  assign o_last = (o_rnd == 4'(C_ROUNDS_A - 1));

  // Clear has priority, then load, then increment.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      o_rnd <= 4'd0;
    end else if (i_load) begin
      o_rnd <= i_load_val;
    end else if (i_inc) begin
      o_rnd <= o_rnd + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_controller.sv
// Sequencing FSM for the ASCON-128 permutation: init, AD, PT, finalization, one round per clock.
// Latency: 12 init rounds, G_ROUNDS_B cycles per data block, tag valid 12 cycles after last PT handshake.
// Backpressure: o_data_ready only in the wait states; a stalled host freezes the datapath (no strobes).
// Optional feature: ASCON_CTRL_ABORT_EN adds i_abort, a synchronous return to IDLE.
module ascon_controller
  import ascon_pkg::*;
#(
  parameter int G_ROUNDS_B = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_ad_present,
  input  logic       i_data_valid,
  input  logic       i_data_last,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       i_abort,
`endif
  output logic       o_data_ready,
  output logic       o_sys_enable,
  output logic       o_mux_select,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_enable_cipher_reg,
  output logic       o_enable_tag_reg,
  output logic       o_enable_state_reg,
  output logic [3:0] o_round,
  output logic       o_cipher_valid,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [2:0] ST_IDLE    = CS_IDLE;
  localparam logic [2:0] ST_INIT    = CS_INIT;
  localparam logic [2:0] ST_AD_WAIT = CS_AD_WAIT;
  localparam logic [2:0] ST_AD_RUN  = CS_AD_RUN;
  localparam logic [2:0] ST_PT_WAIT = CS_PT_WAIT;
  localparam logic [2:0] ST_PT_RUN  = CS_PT_RUN;
  localparam logic [2:0] ST_FINAL   = CS_FINAL;
  localparam logic [2:0] ST_DONE    = CS_DONE;

  // p^b uses the last G_ROUNDS_B round constants of p^a.
  localparam logic [3:0] R_BLK_FIRST = 4'(C_ROUNDS_A - G_ROUNDS_B);
  localparam logic [3:0] R_BLK_NEXT  = 4'(C_ROUNDS_A - G_ROUNDS_B + 1);
  // With a single p^b round the handshake cycle is also the block's final round.
  localparam bit SINGLE_ROUND_B = (G_ROUNDS_B == 1);

  logic [2:0] state, state_nxt;
  logic       ad_present_q, last_q;
  logic       abort, in_wait, hs, start_ok;
  logic       cnt_load, cnt_inc, rnd_last;
  logic [3:0] cnt_val, rnd;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  assign in_wait      = (state == ST_AD_WAIT) || (state == ST_PT_WAIT);
  assign o_data_ready = in_wait && !abort;
  assign hs           = o_data_ready && i_data_valid;
  assign start_ok     = ((state == ST_IDLE) || (state == ST_DONE)) && i_start && !abort;
  assign o_busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done       = (state == ST_DONE);

  ascon_round_counter u_round_counter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (abort),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .i_inc      (cnt_inc),
    .o_rnd      (rnd),
    .o_last     (rnd_last)
  );

  // Permutation strobes and round index decoded from state, round and handshake.
  always_comb begin
    o_mux_select            = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_enable_state_reg      = 1'b0;
    o_round                 = 4'd0;
    case (state)
      ST_INIT: begin
        o_enable_state_reg   = 1'b1;
        o_mux_select         = (rnd != 4'd0);
        o_round              = rnd;
        o_enable_xor_key_end = rnd_last;
        o_enable_xor_lsb_end = rnd_last && !ad_present_q;
      end
      ST_AD_WAIT, ST_PT_WAIT: begin
        // Last PT block starts p^a at round 0; every other block starts p^b.
        o_round = ((state == ST_PT_WAIT) && i_data_last) ? 4'd0 : R_BLK_FIRST;
        if (hs) begin
          o_enable_state_reg      = 1'b1;
          o_mux_select            = 1'b1;
          o_enable_xor_data_begin = 1'b1;
          if (state == ST_PT_WAIT) begin
            o_enable_cipher_reg    = 1'b1;
            o_enable_xor_key_begin = i_data_last;
          end else begin
            o_enable_xor_lsb_end   = SINGLE_ROUND_B && i_data_last;
          end
        end
      end
      ST_AD_RUN: begin
        o_enable_state_reg   = 1'b1;
        o_mux_select         = 1'b1;
        o_round              = rnd;
        o_enable_xor_lsb_end = rnd_last && last_q;
      end
      ST_PT_RUN: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = 1'b1;
        o_round            = rnd;
      end
      ST_FINAL: begin
        o_enable_state_reg   = 1'b1;
        o_mux_select         = 1'b1;
        o_round              = rnd;
        o_enable_xor_key_end = rnd_last;
        o_enable_tag_reg     = rnd_last;
      end
      default: ;
    endcase
  end

  // Next-state and round counter control.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = 4'd0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_nxt = ST_INIT;
          cnt_load  = 1'b1;
        end
      end
      ST_INIT: begin
        if (rnd_last) state_nxt = ad_present_q ? ST_AD_WAIT : ST_PT_WAIT;
        else          cnt_inc   = 1'b1;
      end
      ST_AD_WAIT: begin
        if (hs) begin
          cnt_load = 1'b1;
          cnt_val  = R_BLK_NEXT;
          if (SINGLE_ROUND_B) state_nxt = i_data_last ? ST_PT_WAIT : ST_AD_WAIT;
          else                state_nxt = ST_AD_RUN;
        end
      end
      ST_AD_RUN: begin
        if (rnd_last) state_nxt = last_q ? ST_PT_WAIT : ST_AD_WAIT;
        else          cnt_inc   = 1'b1;
      end
      ST_PT_WAIT: begin
        if (hs) begin
          cnt_load = 1'b1;
          if (i_data_last) begin
            state_nxt = ST_FINAL;
            cnt_val   = 4'd1;
          end else begin
            cnt_val   = R_BLK_NEXT;
            state_nxt = SINGLE_ROUND_B ? ST_PT_WAIT : ST_PT_RUN;
          end
        end
      end
      ST_PT_RUN: begin
        if (rnd_last) state_nxt = ST_PT_WAIT;
        else          cnt_inc   = 1'b1;
      end
      ST_FINAL: begin
        if (rnd_last) state_nxt = ST_DONE;
        else          cnt_inc   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, sticky system enable, cipher-valid pulse and phase flags.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state          <= ST_IDLE;
      o_sys_enable   <= 1'b0;
      o_cipher_valid <= 1'b0;
      ad_present_q   <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_cipher_valid <= hs && (state == ST_PT_WAIT);
      if (start_ok) begin
        o_sys_enable <= 1'b1;
        ad_present_q <= i_ad_present;
      end
      if (hs) last_q <= i_data_last;
    end
  end

endmodule

// File: tb/tb_ascon_controller.sv
// Directed bench for ascon_controller: expected per-cycle outputs queued by stimulus, checked by a monitor.
// Latency: expected entries carry the absolute cycle at which the DUT must show them.
// Backpressure: host stalls are driven explicitly; stalled cycles carry their own expectations.
`timescale 1ns/1ps
module tb_ascon_controller;

  localparam int B = 6;

  localparam logic [7:0] MUX = 8'h80, KB = 8'h40, DB = 8'h20, KE = 8'h10;
  localparam logic [7:0] LE  = 8'h08, CR = 8'h04, TR = 8'h02, SR = 8'h01;
  // {ready, busy, done, sys_enable}
  localparam logic [3:0] FL_OFF = 4'b0000, FL_RUN = 4'b0101, FL_HS = 4'b1101, FL_DONE = 4'b0011;

  typedef struct packed {
    logic [31:0] cy;
    logic [3:0]  rnd;
    logic [7:0]  strb;
    logic        cv;
    logic [3:0]  fl;
  } exp_t;

  logic clock = 1'b0, reset = 1'b1;
  logic i_start = 1'b0, i_ad_present = 1'b0, i_data_valid = 1'b0, i_data_last = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
  logic i_abort = 1'b0;
`endif
  logic o_data_ready, o_sys_enable, o_mux_select, o_enable_xor_key_begin;
  logic o_enable_xor_data_begin, o_enable_xor_key_end, o_enable_xor_lsb_end;
  logic o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg;
  logic [3:0] o_round;
  logic o_cipher_valid, o_busy, o_done;
  logic [7:0] strb;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   stim_done = 1'b0;

  ascon_controller #(.G_ROUNDS_B(B)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .i_start                 (i_start),
    .i_ad_present            (i_ad_present),
    .i_data_valid            (i_data_valid),
    .i_data_last             (i_data_last),
`ifdef ASCON_CTRL_ABORT_EN
    .i_abort                 (i_abort),
`endif
    .o_data_ready            (o_data_ready),
    .o_sys_enable            (o_sys_enable),
    .o_mux_select            (o_mux_select),
    .o_enable_xor_key_begin  (o_enable_xor_key_begin),
    .o_enable_xor_data_begin (o_enable_xor_data_begin),
    .o_enable_xor_key_end    (o_enable_xor_key_end),
    .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
    .o_enable_cipher_reg     (o_enable_cipher_reg),
    .o_enable_tag_reg        (o_enable_tag_reg),
    .o_enable_state_reg      (o_enable_state_reg),
    .o_round                 (o_round),
    .o_cipher_valid          (o_cipher_valid),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  assign strb = {o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin, o_enable_xor_key_end,
                 o_enable_xor_lsb_end, o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Monitor: compare the queued expectation for this cycle, flag unexpected activity.
  always @(negedge clock) begin : monitor
    exp_t e;
    logic [16:0] act, want;
    while (q.size() > 0 && q[0].cy < cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL stale_entry: expectation for cycle %0d never compared (now %0d)", e.cy, cyc);
    end
    act = {o_round, strb, o_cipher_valid, o_data_ready, o_busy, o_done, o_sys_enable};
    if (q.size() > 0 && q[0].cy == cyc) begin
      e = q.pop_front();
      want = {e.rnd, e.strb, e.cv, e.fl};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL cycle_%0d: got rnd %0d strb %b cv %b rdy/busy/done/sys %b, want rnd %0d strb %b cv %b rdy/busy/done/sys %b",
                 cyc, act[16:13], act[12:5], act[4], act[3:0], want[16:13], want[12:5], want[4], want[3:0]);
      end
    end else if (cyc > 0 && (strb !== 8'h00 || o_cipher_valid !== 1'b0)) begin
      checks++; errors++;
      $display("FAIL unexpected_activity cycle_%0d: got strb %b cv %b, want strb 00000000 cv 0",
               cyc, strb, o_cipher_valid);
    end
    if (stim_done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d pending expectations, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic push(int c, int r, logic [7:0] s, logic v, logic [3:0] f);
    exp_t e;
    e.cy = 32'(c); e.rnd = 4'(r); e.strb = s; e.cv = v; e.fl = f;
    q.push_back(e);
  endtask

  // Advance to just after the rising edge that starts cycle c.
  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic exp_init(int t, bit ad, int n);
    for (int r = 0; r < n; r++)
      push(t + 1 + r, r, SR | ((r != 0) ? MUX : 8'h00) | ((r == 11) ? KE : 8'h00) |
           ((r == 11 && !ad) ? LE : 8'h00), 1'b0, FL_RUN);
  endtask

  // Non-final block: handshake round 12-B, then B-1 run rounds.
  task automatic exp_block(int u, bit is_pt, bit last);
    push(u, 12 - B, SR | MUX | DB | (is_pt ? CR : 8'h00), 1'b0, FL_HS);
    for (int k = 1; k < B; k++)
      push(u + k, 12 - B + k, SR | MUX | ((!is_pt && last && (12 - B + k) == 11) ? LE : 8'h00),
           is_pt && (k == 1), FL_RUN);
  endtask

  // Last PT block: p^a round 0 on the handshake, then FINAL rounds 1..n.
  task automatic exp_last_pt(int v, int n);
    push(v, 0, SR | MUX | DB | KB | CR, 1'b0, FL_HS);
    for (int r = 1; r <= n; r++)
      push(v + r, r, SR | MUX | ((r == 11) ? (KE | TR) : 8'h00), r == 1, FL_RUN);
  endtask

  // No AD, single last PT block, host valid as soon as the controller waits.
  task automatic run_simple(int t);
    int v;
    v = t + 13;
    goto(t);
    i_start = 1'b1; i_ad_present = 1'b0;
    exp_init(t, 1'b0, 12);
    exp_last_pt(v, 11);
    push(v + 12, 0, 8'h00, 1'b0, FL_DONE);
    goto(t + 1); i_start = 1'b0;
    goto(v);     i_data_valid = 1'b1; i_data_last = 1'b1;
    goto(v + 1); i_data_valid = 1'b0; i_data_last = 1'b0;
    goto(v + 12);
  endtask

  initial begin
    int t, v;
    // Reset state.
    push(1, 0, 8'h00, 1'b0, FL_OFF);
    push(2, 0, 8'h00, 1'b0, FL_OFF);
    goto(3); reset = 1'b0;

    // Empty AD, one last PT block; INIT round 11 carries key-end and lsb-end.
    run_simple(5);

    // Restart from DONE: two AD blocks and one PT block, host always valid; stray starts ignored.
    t = cyc + 2;
    goto(t);
    i_start = 1'b1; i_ad_present = 1'b1;
    exp_init(t, 1'b1, 12);
    exp_block(t + 13, 1'b0, 1'b0);
    exp_block(t + 19, 1'b0, 1'b1);
    exp_last_pt(t + 25, 11);
    push(t + 37, 0, 8'h00, 1'b0, FL_DONE);
    goto(t + 1);  i_start = 1'b0; i_ad_present = 1'b0;
    goto(t + 3);  i_start = 1'b1;
    goto(t + 4);  i_start = 1'b0;
    goto(t + 13); i_data_valid = 1'b1; i_data_last = 1'b0;
    goto(t + 15); i_start = 1'b1;
    goto(t + 16); i_start = 1'b0;
    goto(t + 19); i_data_last = 1'b1;
    goto(t + 20); i_data_last = 1'b0;
    goto(t + 25); i_data_last = 1'b1;
    goto(t + 26); i_data_valid = 1'b0; i_data_last = 1'b0;
    goto(t + 37);

    // Host stalls 5 cycles in PT_WAIT, then a non-last and a last PT block.
    t = cyc + 2;
    goto(t);
    i_start = 1'b1; i_ad_present = 1'b0;
    exp_init(t, 1'b0, 12);
    for (int k = 13; k < 18; k++) push(t + k, 12 - B, 8'h00, 1'b0, FL_HS);
    exp_block(t + 18, 1'b1, 1'b0);
    exp_last_pt(t + 24, 11);
    push(t + 36, 0, 8'h00, 1'b0, FL_DONE);
    goto(t + 1);  i_start = 1'b0;
    goto(t + 18); i_data_valid = 1'b1; i_data_last = 1'b0;
    goto(t + 19); i_data_valid = 1'b0;
    goto(t + 24); i_data_valid = 1'b1; i_data_last = 1'b1;
    goto(t + 25); i_data_valid = 1'b0; i_data_last = 1'b0;
    goto(t + 36);

    // Reset held 3 cycles in the middle of FINAL.
    t = cyc + 2;
    v = t + 13;
    goto(t);
    i_start = 1'b1;
    exp_init(t, 1'b0, 12);
    exp_last_pt(v, 5);
    push(v + 6, 0, 8'h00, 1'b0, FL_OFF);
    push(v + 7, 0, 8'h00, 1'b0, FL_OFF);
    push(v + 8, 0, 8'h00, 1'b0, FL_OFF);
    goto(t + 1); i_start = 1'b0;
    goto(v);     i_data_valid = 1'b1; i_data_last = 1'b1;
    goto(v + 1); i_data_valid = 1'b0; i_data_last = 1'b0;
    goto(v + 5); reset = 1'b1;
    goto(v + 8); reset = 1'b0;

`ifdef ASCON_CTRL_ABORT_EN
    // Abort at INIT round 5, then a complete run.
    t = cyc + 2;
    goto(t);
    i_start = 1'b1;
    exp_init(t, 1'b0, 6);
    push(t + 7, 0, 8'h00, 1'b0, FL_OFF);
    goto(t + 1); i_start = 1'b0;
    goto(t + 6); i_abort = 1'b1;
    goto(t + 7); i_abort = 1'b0;
    run_simple(t + 9);
`endif

    goto(cyc + 3);
    stim_done = 1'b1;
  end

endmodule
